// File: rtl/clk_div_pkg.sv
// Shared widths, reset defaults and rate constants for the clock-divider bank.
// Rate constants assume a 100 MHz system clock.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF = 27;

    typedef logic [CNT_W_DEF-1:0] half_t;

    // Output period is 2*(H+1) cycles, so H = period/2 - 1
    function automatic half_t period_to_half(input int unsigned period);
        return half_t'(period / 2 - 1);
    endfunction

    localparam half_t HALF_1HZ_100M    = period_to_half(100_000_000);
    localparam half_t HALF_1KHZ_100M   = period_to_half(100_000);
    localparam half_t HALF_60HZ_100M   = period_to_half(1_666_667);
    localparam half_t DEFAULT_HALF_DEF = HALF_1HZ_100M;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, live and pending divide values,
// registered 50%-duty slow clock and rising-edge tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned      CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_half,
    input  logic             align,
    output logic             slow_clk,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pending_q, pending_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        slow_d     = slow_q;
        tick_d     = 1'b0;
        if (align) begin
            cnt_d  = '0;
            slow_d = 1'b0;
            if (pending_q) begin
                half_d    = pend_val_q;
                pending_d = 1'b0;
            end
        end else if (wr_hit && !en) begin
            half_d    = wr_half;
            cnt_d     = '0;
            slow_d    = 1'b0;
            pending_d = 1'b0;
        end else begin
            if (en) begin
                if (cnt_q == half_q) begin
                    cnt_d  = '0;
                    slow_d = ~slow_q;
                    tick_d = ~slow_q;
                    // Falling edge closes a full period; a same-cycle write defers to the next one
                    if (slow_q && pending_q && !wr_hit) begin
                        half_d    = pend_val_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (wr_hit) begin
                pend_val_d = wr_half;
                pending_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            half_q     <= DEFAULT_HALF;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            slow_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            slow_q     <= slow_d;
            tick_q     <= tick_d;
        end
    end

    assign slow_clk = slow_q;
    assign tick     = tick_q;
    assign pending  = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers sharing one write port.
// Optional CLK_DIV_BANK_PHASE_ALIGN_EN adds an align input that phase-resets all channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned      NUM_CH       = 4,
    parameter int unsigned      CNT_W        = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_DEF),
    parameter int unsigned      SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_BANK_PHASE_ALIGN_EN
    input  logic              align,
`endif
    input  logic              wr,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] slow_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic align_w;
    logic [NUM_CH-1:0] wr_hit;

`ifdef CLK_DIV_BANK_PHASE_ALIGN_EN
    assign align_w = align;
`else
    assign align_w = 1'b0;
`endif

    // Out-of-range selects match no channel, so such writes fall away
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_hit[g] = wr && (wr_sel == SEL_W'(g));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[g]),
            .wr_hit  (wr_hit[g]),
            .wr_half (wr_half),
            .align   (align_w),
            .slow_clk(slow_clk[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule
